// File: rtl/decode_queue_pkg.sv
// RV32I decode types, the decode packet layout and the shared rv32i_decode() function.
// Define DECODE_QUEUE_RV32M_EN to decode the M-extension (funct7=0000001) under op_reg.
package decode_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  // Encodings line up with arith funct3 so most ops pass funct3 straight through.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    imm_none = 3'd0,
    imm_i    = 3'd1,
    imm_s    = 3'd2,
    imm_b    = 3'd3,
    imm_u    = 3'd4,
    imm_j    = 3'd5
  } imm_sel_t;

  typedef enum logic {alu1_rs1 = 1'b0, alu1_pc = 1'b1} alu_m1_sel_t;
  typedef enum logic {alu2_imm = 1'b0, alu2_rs2 = 1'b1} alu_m2_sel_t;
  typedef enum logic {cmp_rs2 = 1'b0, cmp_imm = 1'b1} cmp_sel_t;

  typedef enum logic [2:0] {
    rfm_alu      = 3'd0,
    rfm_br_en    = 3'd1,
    rfm_u_imm    = 3'd2,
    rfm_load     = 3'd3,
    rfm_pc_plus4 = 3'd4
  } regfilemux_sel_t;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    imm_sel_t        imm_sel;
    logic [31:0]     imm;
    alu_m1_sel_t     alu_m1_sel;
    alu_m2_sel_t     alu_m2_sel;
    alu_ops          alu_op;
    cmp_sel_t        cmp_sel;
    branch_funct3_t  cmpop;
    logic            regf_we;
    regfilemux_sel_t regfilemux_sel;
    logic            illegal;
    logic            muldiv;
  } decode_pkt_t;

  localparam int PKT_W = $bits(decode_pkt_t);

  function automatic decode_pkt_t rv32i_decode(input logic [31:0] pc, input logic [31:0] inst);
    decode_pkt_t p;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        known;
    logic        alt;

    opc   = inst[6:0];
    f3    = inst[14:12];
    alt   = inst[30];
    known = 1'b1;
    i_imm = {{21{inst[31]}}, inst[30:20]};
    s_imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    u_imm = {inst[31:12], 12'h000};
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    p                = '0;
    p.pc             = pc;
    p.inst           = inst;
    p.opcode         = opc;
    p.funct3         = f3;
    p.funct7         = inst[31:25];
    p.rs1_s          = inst[19:15];
    p.rs2_s          = inst[24:20];
    p.rd_s           = inst[11:7];
    p.imm_sel        = imm_none;
    p.alu_m1_sel     = alu1_rs1;
    p.alu_m2_sel     = alu2_imm;
    p.alu_op         = alu_add;
    p.cmp_sel        = cmp_rs2;
    p.cmpop          = beq;
    p.regfilemux_sel = rfm_alu;
    p.muldiv         = 1'b0;

    case (opc)
      op_lui: begin
        p.imm_sel        = imm_u;
        p.regfilemux_sel = rfm_u_imm;
      end
      op_auipc: begin
        p.imm_sel    = imm_u;
        p.alu_m1_sel = alu1_pc;
      end
      op_jal: begin
        p.imm_sel        = imm_j;
        p.alu_m1_sel     = alu1_pc;
        p.regfilemux_sel = rfm_pc_plus4;
      end
      op_jalr: begin
        p.imm_sel        = imm_i;
        p.regfilemux_sel = rfm_pc_plus4;
      end
      op_br: begin
        p.imm_sel    = imm_b;
        p.alu_m1_sel = alu1_pc;
        p.cmpop      = branch_funct3_t'(f3);
      end
      op_load: begin
        p.imm_sel        = imm_i;
        p.regfilemux_sel = rfm_load;
      end
      op_store: begin
        p.imm_sel = imm_s;
      end
      op_imm: begin
        p.imm_sel = imm_i;
        case (f3)
          f3_slt: begin
            p.cmp_sel        = cmp_imm;
            p.cmpop          = blt;
            p.regfilemux_sel = rfm_br_en;
          end
          f3_sltu: begin
            p.cmp_sel        = cmp_imm;
            p.cmpop          = bltu;
            p.regfilemux_sel = rfm_br_en;
          end
          f3_sr:   p.alu_op = alt ? alu_sra : alu_srl;
          default: p.alu_op = alu_ops'(f3);
        endcase
      end
      op_reg: begin
        p.alu_m2_sel = alu2_rs2;
        if (inst[31:25] == F7_MULDIV) begin
`ifdef DECODE_QUEUE_RV32M_EN
          p.muldiv = 1'b1;
          p.alu_op = alu_ops'(f3);
`else
          known = 1'b0;
`endif
        end else if (inst[31:25] != F7_BASE && inst[31:25] != F7_ALT) begin
          known = 1'b0;
        end else begin
          case (f3)
            f3_add: p.alu_op = alt ? alu_sub : alu_add;
            f3_sr:  p.alu_op = alt ? alu_sra : alu_srl;
            f3_slt: begin
              p.cmpop          = blt;
              p.regfilemux_sel = rfm_br_en;
            end
            f3_sltu: begin
              p.cmpop          = bltu;
              p.regfilemux_sel = rfm_br_en;
            end
            default: p.alu_op = alu_ops'(f3);
          endcase
        end
      end
      op_csr: begin
      end
      default: known = 1'b0;
    endcase

    case (p.imm_sel)
      imm_i:   p.imm = i_imm;
      imm_s:   p.imm = s_imm;
      imm_b:   p.imm = b_imm;
      imm_u:   p.imm = u_imm;
      imm_j:   p.imm = j_imm;
      default: p.imm = 32'h0;
    endcase

    if (opc == op_lui || opc == op_auipc || opc == op_jal) p.rs1_s = 5'd0;
    if (!(opc == op_reg || opc == op_store || opc == op_br)) p.rs2_s = 5'd0;

    p.illegal = ~known;
    p.regf_we = known && (opc != op_br) && (opc != op_store) && (p.rd_s != 5'd0);
    return p;
  endfunction

endpackage

// File: rtl/decode_queue_inst_queue.sv
// Circular FIFO of {pc,inst} words with synchronous flush; storage is cleared on reset.
module inst_queue #(
  parameter int  DEPTH = 4,
  parameter int  W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [W-1:0]     push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [W-1:0]     pop_data_o,
  output logic [CNT_W-1:0] occupancy_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  // Ready ignores pop_ready so no combinational path runs from execute back to fetch.
  assign push_ready_o = (cnt_q != CNT_W'(DEPTH)) & ~rst;
  assign pop_valid_o  = (cnt_q != '0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign occupancy_o  = cnt_q;

  always_comb begin
    push_en  = push_valid_i & push_ready_o & ~flush_i;
    pop_en   = pop_valid_o & pop_ready_i & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-execute instruction queue with combinational RV32I decode of the head entry.
// Define DECODE_QUEUE_RV32M_EN to accept and flag M-extension instructions.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PKT_W-1:0] id_pkt,
  output logic [CNT_W-1:0] occupancy
);

  logic [63:0] head_data;
  decode_pkt_t head_pkt;

  inst_queue #(
    .DEPTH(DEPTH),
    .W    (64)
  ) u_inst_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_valid_i(if_valid),
    .push_ready_o(if_ready),
    .push_data_i ({if_pc, if_inst}),
    .pop_valid_o (id_valid),
    .pop_ready_i (id_ready),
    .pop_data_o  (head_data),
    .occupancy_o (occupancy)
  );

  // An empty queue presents a harmless NOP at pc 0 so execute never sees stale fields.
  always_comb begin
    if (id_valid) begin
      head_pkt = rv32i_decode(head_data[63:32], head_data[31:0]);
    end else begin
      head_pkt         = rv32i_decode(32'h0, NOP_INST);
      head_pkt.regf_we = 1'b0;
    end
    id_pkt = head_pkt;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a {pc,inst} scoreboard tracks queue contents, decode fields checked per step.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [PKT_W-1:0] id_pkt;
  logic [CNT_W-1:0] occupancy;
  decode_pkt_t      pkt;

  logic [63:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pkt   (id_pkt),
    .occupancy(occupancy)
  );

  assign pkt = decode_pkt_t'(id_pkt);

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks status against the scoreboard, then clocks and updates the scoreboard.
  task automatic tick();
    logic doPush;
    logic doPop;
    #1;
    checkOutput("occupancy", 64'(occupancy), 64'(sb.size()));
    checkOutput("if_ready", 64'(if_ready), 64'(!rst && sb.size() != DEPTH));
    checkOutput("id_valid", 64'(id_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) checkOutput("head_pc_inst", {pkt.pc, pkt.inst}, sb[0]);
    doPush = if_valid && !rst && (sb.size() != DEPTH);
    doPop  = id_ready && (sb.size() != 0);
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (doPop) void'(sb.pop_front());
      if (doPush) sb.push_back({if_pc, if_inst});
    end
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
    tick();
  endtask

  initial begin
    logic [31:0] lastPc;
    logic [31:0] curPc;

    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0; id_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state, with if_ready held low while rst is asserted.
    applyStimulus(1'b1, 32'h6000_0000, 32'h00500093, 1'b0, 1'b0);
    checkOutput("rst_empty_pc", 64'(pkt.pc), 64'h0);
    checkOutput("rst_empty_inst", 64'(pkt.inst), 64'h00000013);
    checkOutput("rst_empty_we", 64'(pkt.regf_we), 64'h0);
    rst = 1'b0;

    // addi x1,x0,5 is visible one cycle after the push.
    applyStimulus(1'b1, 32'h6000_0000, 32'h00500093, 1'b0, 1'b0);
    if_valid = 1'b0;
    #1;
    checkOutput("addi_valid", 64'(id_valid), 64'h1);
    checkOutput("addi_imm", 64'(pkt.imm), 64'h5);
    checkOutput("addi_rd", 64'(pkt.rd_s), 64'h1);
    checkOutput("addi_rs2", 64'(pkt.rs2_s), 64'h0);
    checkOutput("addi_we", 64'(pkt.regf_we), 64'h1);
    checkOutput("addi_illegal", 64'(pkt.illegal), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to DEPTH with execute stalled; a fifth word is refused.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h6000_0010 + 32'(4 * i), 32'h00000093 | (32'(i) << 20), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6000_0020, 32'h00900093, 1'b0, 1'b0);
    checkOutput("full_occ", 64'(occupancy), 64'd4);
    checkOutput("full_ready", 64'(if_ready), 64'h0);
    applyStimulus(1'b1, 32'h6000_0020, 32'h00900093, 1'b1, 1'b0);
    checkOutput("ready_after_pop", 64'(if_ready), 64'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming push+pop at occupancy 2 across pointer wrap.
    lastPc = 32'h6000_0014;
    for (int i = 0; i < 10; i++) begin
      curPc = pkt.pc;
      checkOutput("pc_increasing", 64'(curPc > lastPc), 64'h1);
      lastPc = curPc;
      applyStimulus(1'b1, 32'h6000_0100 + 32'(4 * i), 32'h00100113, 1'b1, 1'b0);
    end
    checkOutput("stream_occ", 64'(occupancy), 64'd2);

    // Flush at occupancy 3 drops everything including the same-cycle push.
    applyStimulus(1'b1, 32'h6000_0200, 32'h00100113, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6000_0204, 32'h00200113, 1'b0, 1'b1);
    checkOutput("flush_occ", 64'(occupancy), 64'd0);
    checkOutput("flush_valid", 64'(id_valid), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // sub x3,x1,x2
    applyStimulus(1'b1, 32'h6000_0300, 32'h402081B3, 1'b0, 1'b0);
    checkOutput("sub_aluop", 64'(pkt.alu_op), 64'(alu_sub));
    checkOutput("sub_we", 64'(pkt.regf_we), 64'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // sw x2,0(x1)
    applyStimulus(1'b1, 32'h6000_0304, 32'h0020A023, 1'b0, 1'b0);
    checkOutput("sw_we", 64'(pkt.regf_we), 64'h0);
    checkOutput("sw_imm", 64'(pkt.imm), 64'h0);
    checkOutput("sw_rs2", 64'(pkt.rs2_s), 64'h2);
    checkOutput("sw_rs1", 64'(pkt.rs1_s), 64'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // addi x0,x0,0 never writes the register file.
    applyStimulus(1'b1, 32'h6000_0308, 32'h00000013, 1'b0, 1'b0);
    checkOutput("nop_we", 64'(pkt.regf_we), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // lui x5,0x12345: rs1 field is forced to zero.
    applyStimulus(1'b1, 32'h6000_030C, 32'h123452B7, 1'b0, 1'b0);
    checkOutput("lui_imm", 64'(pkt.imm), 64'h12345000);
    checkOutput("lui_rs1", 64'(pkt.rs1_s), 64'h0);
    checkOutput("lui_we", 64'(pkt.regf_we), 64'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // mul x3,x1,x2
    applyStimulus(1'b1, 32'h6000_0310, 32'h022081B3, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_RV32M_EN
    checkOutput("mul_muldiv", 64'(pkt.muldiv), 64'h1);
    checkOutput("mul_illegal", 64'(pkt.illegal), 64'h0);
    checkOutput("mul_we", 64'(pkt.regf_we), 64'h1);
`else
    checkOutput("mul_muldiv", 64'(pkt.muldiv), 64'h0);
    checkOutput("mul_illegal", 64'(pkt.illegal), 64'h1);
    checkOutput("mul_we", 64'(pkt.regf_we), 64'h0);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // All-ones word is an unknown opcode but is still dequeued.
    applyStimulus(1'b1, 32'h6000_0314, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("ones_illegal", 64'(pkt.illegal), 64'h1);
    checkOutput("ones_we", 64'(pkt.regf_we), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
